// File: rtl/des_pkg.sv
// Shared constants and FSM state encoding for the DES result collector.
package des_pkg;
    localparam int CNT_W     = 64;
    localparam int NUM_CORES = 6;
    localparam int SLOT_W    = CNT_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESTART,
        S_LAUNCH,
        S_WAIT,
        S_ACCUM,
        S_DONE
    } state_e;
endpackage

// File: rtl/des_result_adder.sv
// Sequential accumulator: adds one slot per enabled cycle, walks an index 0..NUM_CORES-1,
// tracks a sticky carry-out. One cycle per addend; no backpressure.
module des_result_adder #(
    parameter int NUM_CORES = 6,
    parameter int CNT_W     = 64,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] addend_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             last_o,
    output logic [CNT_W-1:0] sum_o,
    output logic             ovf_o
);
    import des_pkg::*;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W:0]   wide_sum;

    assign wide_sum = {1'b0, sum_q} + {1'b0, addend_i};
    assign last_o   = (idx_q == IDX_W'(NUM_CORES - 1));

    always_comb begin
        idx_d = idx_q;
        sum_d = sum_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            idx_d = '0;
            sum_d = '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            sum_d = wide_sum[CNT_W-1:0];
            ovf_d = ovf_q | wide_sum[CNT_W];
            idx_d = last_o ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign idx_o = idx_q;
    assign sum_o = sum_q;
    assign ovf_o = ovf_q;
endmodule

// File: rtl/des_result_collector.sv
// Launches all DES cores, captures each counter on its first done, sums them serially,
// reports total and deviation from NUM_CORES*limit/2. Result after last capture + NUM_CORES+2 edges.
module des_result_collector #(
    parameter int NUM_CORES = des_pkg::NUM_CORES,
    parameter int CNT_W     = des_pkg::CNT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [CNT_W-1:0]           counter_limit,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES*CNT_W-1:0] core_counter,
    output logic                       core_start,
    output logic                       core_restart,
    output logic                       busy,
    output logic                       done,
    output logic [CNT_W-1:0]           total_count,
    output logic [CNT_W-1:0]           deviation,
    output logic                       overflow
);
    import des_pkg::*;

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_e                 state_q, state_d;
    logic [NUM_CORES-1:0]   captured_q, captured_d, cap_en;
    logic [CNT_W-1:0]       slot_q [NUM_CORES];
    logic [CNT_W-1:0]       limit_q;
    logic                   core_start_q, core_restart_q, busy_q, done_q;
    logic [CNT_W-1:0]       dev_q;
    logic                   launch, done_entry;
    logic [IDX_W-1:0]       acc_idx;
    logic                   acc_last;
    logic [CNT_W+3:0]       expect_full, expect_half;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_LAUNCH;
            S_RESTART: state_d = S_LAUNCH;
            S_LAUNCH:  state_d = S_WAIT;
            S_WAIT:    if (&captured_q) state_d = S_ACCUM;
            S_ACCUM:   if (acc_last) state_d = S_DONE;
            // The entry cycle of DONE still has to publish the result.
            S_DONE:    if (start && done_q) state_d = S_RESTART;
            default:   state_d = S_IDLE;
        endcase
    end

    assign launch     = (state_d == S_LAUNCH);
    assign done_entry = (state_q == S_DONE) && !done_q;
    assign cap_en     = (state_q == S_WAIT) ? (core_done & ~captured_q) : '0;
    assign captured_d = launch ? '0 : (captured_q | cap_en);

    assign expect_full = (CNT_W+4)'(NUM_CORES) * {4'd0, limit_q};
    assign expect_half = expect_full >> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            captured_q     <= '0;
            limit_q        <= '0;
            core_start_q   <= 1'b0;
            core_restart_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            dev_q          <= '0;
            for (int i = 0; i < NUM_CORES; i++) slot_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            captured_q     <= captured_d;
            core_start_q   <= launch;
            core_restart_q <= (state_d == S_RESTART);
            for (int i = 0; i < NUM_CORES; i++) begin
                if (cap_en[i]) slot_q[i] <= core_counter[i*CNT_W +: CNT_W];
            end
            if (launch) begin
                limit_q <= counter_limit;
                done_q  <= 1'b0;
                busy_q  <= 1'b1;
            end else if (state_d == S_RESTART) begin
                busy_q  <= 1'b1;
            end else if (done_entry) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                dev_q   <= total_count - expect_half[CNT_W-1:0];
            end
        end
    end

    des_result_adder #(
        .NUM_CORES (NUM_CORES),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) u_adder (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (launch),
        .en_i     (state_q == S_ACCUM),
        .addend_i (slot_q[acc_idx]),
        .idx_o    (acc_idx),
        .last_o   (acc_last),
        .sum_o    (total_count),
        .ovf_o    (overflow)
    );

    assign core_start   = core_start_q;
    assign core_restart = core_restart_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign deviation    = dev_q;
endmodule

// File: tb/tb_des_result_collector.sv
// Directed bench for des_result_collector with hand-computed expected results.
module tb_des_result_collector;
    localparam int N = 6;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   counter_limit;
    logic [N-1:0]   core_done;
    logic [N*W-1:0] core_counter;
    logic           core_start, core_restart, busy, done, overflow;
    logic [W-1:0]   total_count, deviation;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    des_result_collector #(.NUM_CORES(N), .CNT_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .counter_limit (counter_limit),
        .core_done     (core_done),
        .core_counter  (core_counter),
        .core_start    (core_start),
        .core_restart  (core_restart),
        .busy          (busy),
        .done          (done),
        .total_count   (total_count),
        .deviation     (deviation),
        .overflow      (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic [W-1:0] v);
        core_counter[i*W +: W] = v;
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) set_slot(i, v);
    endtask

    // Called just before the edge that samples the last core_done; returns edges until done.
    task automatic wait_done(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (done === 1'b1) begin
                lat = c - 1;
                break;
            end
        end
        check(tag, W'(lat), W'(exp_lat));
    endtask

    // Start pulse from DONE: RESTART cycle, then LAUNCH cycle, leaves FSM entering WAIT.
    task automatic restart_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        counter_limit = 64'h1000;
        core_done     = '0;
        core_counter  = '0;
        tick();
        tick();
        check("rst_done",  W'(done), 0);
        check("rst_busy",  W'(busy), 0);
        check("rst_total", total_count, 0);
        check("rst_dev",   deviation, 0);
        check("rst_ovf",   W'(overflow), 0);
        check("rst_pulse", W'({core_start, core_restart}), 0);
        rst_n = 1'b1;
        tick();

        // Run 1: all counters 0x800, cores done at cycle 20
        set_all(64'h800);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r1_core_start", W'(core_start), 1);
        check("r1_restart",    W'(core_restart), 0);
        check("r1_busy",       W'(busy), 1);
        tick();
        check("r1_start_1cyc", W'(core_start), 0);
        repeat (16) tick();
        core_done = '1;
        wait_done("r1_latency", 8);
        check("r1_total", total_count, 64'h3000);
        check("r1_dev",   deviation, 64'h0);
        check("r1_ovf",   W'(overflow), 0);
        check("r1_busy",  W'(busy), 0);

        // Run 2: restart from DONE, staggered finish, ignored start in WAIT
        core_done = '0;
        set_slot(0, 64'h801); set_slot(1, 64'h7FF); set_slot(2, 64'h810);
        set_slot(3, 64'h800); set_slot(4, 64'h7F0); set_slot(5, 64'h800);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r2_restart_pulse", W'({core_restart, core_start}), 64'h2);
        tick();
        check("r2_launch_pulse",  W'({core_restart, core_start}), 64'h1);
        check("r2_clr_done",      W'(done), 0);
        check("r2_clr_total",     total_count, 0);
        check("r2_busy",          W'(busy), 1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r2_wait_start_ign", W'({core_restart, core_start}), 0);
        core_done[5] = 1'b1;
        tick();
        set_slot(5, 64'hFFFF);
        core_done[5] = 1'b0;
        core_done[4] = 1'b1;
        tick();
        core_done[3] = 1'b1;
        tick();
        core_done[2] = 1'b1;
        core_done[1] = 1'b1;
        tick();
        check("r2_not_done_yet", W'(done), 0);
        core_done[0] = 1'b1;
        wait_done("r2_latency", 8);
        check("r2_total", total_count, 64'h3000);
        check("r2_dev",   deviation, 64'h0);

        // Run 3: negative deviation
        core_done = '0;
        set_all(64'h700);
        restart_run();
        tick();
        core_done = '1;
        wait_done("r3_latency", 8);
        check("r3_total", total_count, 64'h2A00);
        check("r3_dev",   deviation, 64'hFFFF_FFFF_FFFF_FA00);
        check("r3_ovf",   W'(overflow), 0);

        // Run 4: carry out of the sum
        core_done = '0;
        set_all(64'h1);
        set_slot(0, 64'h8000_0000_0000_0005);
        set_slot(1, 64'h8000_0000_0000_0005);
        restart_run();
        core_done = '1;
        wait_done("r4_latency", 8);
        check("r4_ovf",   W'(overflow), 1);
        check("r4_total", total_count, 64'hE);
        check("r4_dev",   deviation, 64'hE - 64'h3000);

        // Run 5: reset during ACCUM, then a clean run
        core_done = '0;
        set_all(64'h900);
        restart_run();
        core_done = '1;
        tick();
        tick();
        tick();
        check("r5_busy_accum", W'(busy), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        core_done = '0;
        check("r5_rst_done",  W'(done), 0);
        check("r5_rst_busy",  W'(busy), 0);
        check("r5_rst_total", total_count, 0);
        check("r5_rst_dev",   deviation, 0);
        check("r5_rst_ovf",   W'(overflow), 0);
        check("r5_rst_pulse", W'({core_start, core_restart}), 0);
        tick();
        check("r5_idle_pulse", W'({core_start, core_restart}), 0);
        set_all(64'h800);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r5_core_start", W'({core_restart, core_start}), 64'h1);
        tick();
        tick();
        core_done = '1;
        wait_done("r5_latency", 8);
        check("r5_total", total_count, 64'h3000);
        check("r5_dev",   deviation, 64'h0);
        check("r5_ovf",   W'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/des_result_collector.md
# des_result_collector

Downstream stage of the six `des_block` cores. Launches all cores with one `core_start` pulse and captures each core's `counter` when its `done` is first seen. Sums the captured counters one per cycle and reports the total plus its signed deviation from the expected unbiased count. The AXI wrapper sees a single `done`/`total_count` instead of six.

## Interface
- `NUM_CORES`, 6, number of `des_block` instances served (1..16)
- `CNT_W`, 64, width of each core counter and of the total
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low
- `start`  in  1  run request (level sampled; acted on only in IDLE or DONE)
- `counter_limit`  in  CNT_W  per-core sample count, same value driven to the cores
- `core_done`  in  NUM_CORES  per-core done, bit i from core i (level)
- `core_counter`  in  NUM_CORES*CNT_W  core i counter at bits [i*CNT_W +: CNT_W]
- `core_start`  out  1  one-cycle launch pulse to all cores
- `core_restart`  out  1  one-cycle `restart_block` pulse to all cores
- `busy`  out  1  high from accepted start until done
- `done`  out  1  result valid; held until next accepted start
- `total_count`  out  CNT_W  sum of captured counters
- `deviation`  out  CNT_W  two's-complement total − (NUM_CORES*counter_limit)/2
- `overflow`  out  1  sticky: a carry out of CNT_W occurred in the sum

## Operation
- States: IDLE, RESTART, LAUNCH, WAIT, ACCUM, DONE.
- IDLE + start → LAUNCH.
- DONE + start → RESTART. RESTART lasts one cycle with `core_restart`=1, then goes to LAUNCH.
- LAUNCH lasts one cycle with `core_start`=1. It clears the captured flags, `total_count`, `overflow` and `done`, then goes to WAIT.
- WAIT capture rule, per core i: if `core_done[i]`=1 and `captured[i]`=0, latch `core_counter[i]` into slot i and set `captured[i]`.
  - Later changes on a captured core are ignored.
  - Several cores may capture in the same cycle.
- WAIT → ACCUM on the cycle after all `captured` bits are 1.
- ACCUM has an index 0..NUM_CORES−1. Each cycle it adds slot[index] into `total_count`, in CNT_W+1 bits.
  - A carry sets `overflow`; the sum stored is mod 2^CNT_W.
  - After index NUM_CORES−1 → DONE.
- DONE entry cycle computes `deviation` = total_count − ((NUM_CORES*counter_limit) >> 1).
  - The product is computed at full width (CNT_W+4 bits) and the result is truncated to CNT_W.
  - `counter_limit` is sampled at LAUNCH and held internally.
- DONE: `done`=1 and outputs are stable until the next accepted start.
- `start` is ignored in RESTART, LAUNCH, WAIT and ACCUM.
- `core_done` activity outside WAIT is ignored.
- Reset (synchronous, any state) → IDLE. All outputs go to 0, including `deviation` and `overflow`. Slots and flags are cleared. No pulse is emitted in the reset cycle.

## Timing
- All outputs are registered.
- `start` sampled high at edge k in IDLE → `core_start` high for the cycle after edge k, exactly one cycle.
- In DONE, `core_restart` precedes `core_start` by one cycle.
- `busy` rises together with the first of `core_restart`/`core_start` and falls when `done` rises.
- Capture latency: `core_done[i]` high at edge m → slot i valid after edge m.
- Last capture at edge m → ACCUM entered at m+1 → `done` and `deviation` valid after edge m+NUM_CORES+2.
- With NUM_CORES=6: `done` is high 8 cycles after the last core's done is sampled.
- Core done already high when entering WAIT (stale level from a previous run without restart) is captured immediately. Software must pulse start from DONE to force the restart.

## Structure
- Shared package `des_pkg` holds:
  - `CNT_W`, `NUM_CORES`;
  - the state enum;
  - the `core_counter` slice helper constant `SLOT_W`.
- Optional sub-module `des_result_adder`: sequential accumulator with index counter, carry and sticky overflow. The FSM and capture logic stay in the top.
- Expected size ~200 lines of RTL.

## Test plan
- Reset then start, with all cores done at cycle 20 and counters 0x800 each, `counter_limit`=0x1000 → `total_count`=0x3000, `deviation`=0, `done` 8 cycles later.
- Cores finish staggered (core 5 first, core 0 last), counters 0x801,0x7FF,0x810,0x800,0x7F0,0x800 → total 0x3000, `deviation`=0. Counter changes after capture are ignored.
- All counters 0x700, `counter_limit`=0x1000 → `deviation`=0xFFFF_FFFF_FFFF_FA00 (−0x600).
- Start again from DONE → `core_restart` pulse, then `core_start` pulse next cycle. Outputs clear at LAUNCH. A start during WAIT produces no extra pulse.
- Counters of 2^63 on two cores → `overflow`=1 and `total_count` wraps mod 2^64.
- `rst_n` low during ACCUM → next cycle IDLE, all outputs 0. A following start runs cleanly.
